wb_bus_arbiter2: RTL and testbench

//  2-master -> 1-slave Wishbone classic arbiter placed between the core wrapper's IBUS and DBUS

---
 rtl/wb_bus_arbiter2_pkg.sv | 36 +++
 rtl/wb_bus_arbiter2_wdt.sv | 33 +++
 rtl/wb_bus_arbiter2.sv | 143 ++++++++++++++
 tb/tb_wb_bus_arbiter2.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_arbiter2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_arbiter2_pkg
// Desc     : Shared encodings for the 2-master Wishbone arbiter: FSM states,
//            last-served tracking, grant bit positions, default timeout data.
// Revision : 1.0 - initial release
// ============================================================================
package wb_bus_arbiter2_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GNT_I = 2'd1,
      ARB_GNT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      SRC_I = 1'b0,
      SRC_D = 1'b1
   } arb_src_t;

   localparam int GNT_I_BIT = 0;
   localparam int GNT_D_BIT = 1;

   localparam logic [31:0] TIMEOUT_DATA_DEFAULT = 32'hDEADBEEF;

   // One-hot grant vector {dbus,ibus} for a given arbiter state
   function automatic logic [1:0] grant_of(input arb_state_t s);
      logic [1:0] g;
      g            = 2'b00;
      g[GNT_I_BIT] = (s == ARB_GNT_I);
      g[GNT_D_BIT] = (s == ARB_GNT_D);
      return g;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_bus_arbiter2_wdt.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_arbiter2_wdt
// Desc     : Stall watchdog for the arbiter. Counts granted, strobed cycles
//            without ack and flags the cycle in which the limit is reached.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter2_wdt #(
   parameter int unsigned TIMEOUT_CYC = 255
)(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   input  logic active,
   output logic fire
);

   logic [7:0] cnt;

   // Stall counter: restarts on ack, forced termination or grant change
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= 8'd0;
      end else if (inc && (cnt != 8'hFF)) begin
         cnt <= cnt + 8'd1;
      end
   end

   assign fire = active && (cnt == TIMEOUT_CYC[7:0]);

endmodule
`default_nettype wire

// File: rtl/wb_bus_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : wb_bus_arbiter2
// Desc     : 2-master (IBUS, DBUS) to 1-slave Wishbone classic arbiter.
//            Grant is held for the whole cyc; round-robin or fixed DBUS
//            priority on simultaneous requests from idle.
//            Optional stall timeout enabled by macro WB_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module wb_bus_arbiter2
   import wb_bus_arbiter2_pkg::*;
#(
   parameter bit          RR_EN        = 1'b1,
   parameter int unsigned TIMEOUT_CYC  = 255,
   parameter logic [31:0] TIMEOUT_DATA = TIMEOUT_DATA_DEFAULT
)(
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [31:0] i_adr_i,
   input  logic        i_cyc_i,
   output logic [31:0] i_dat_o,
   output logic        i_ack_o,
   input  logic [31:0] d_adr_i,
   input  logic [31:0] d_dat_i,
   input  logic        d_we_i,
   input  logic [3:0]  d_sel_i,
   input  logic        d_stb_i,
   input  logic        d_cyc_i,
   output logic [31:0] d_dat_o,
   output logic        d_ack_o,
   output logic [31:0] s_adr_o,
   output logic [31:0] s_dat_o,
   output logic        s_we_o,
   output logic [3:0]  s_sel_o,
   output logic        s_stb_o,
   output logic        s_cyc_o,
   input  logic [31:0] s_dat_i,
   input  logic        s_ack_i,
   output logic [1:0]  gnt_o,
   output logic        timeout_o
);

   arb_state_t state;
   arb_state_t nxt_state;
   arb_src_t   last;
   logic       fire;

   // Next grant: owner keeps the bus while its cyc is high, else hand over
   always_comb begin
      nxt_state = state;
      case (state)
         ARB_IDLE: begin
            if (i_cyc_i && d_cyc_i) begin
               nxt_state = (RR_EN && (last == SRC_D)) ? ARB_GNT_I : ARB_GNT_D;
            end else if (d_cyc_i) begin
               nxt_state = ARB_GNT_D;
            end else if (i_cyc_i) begin
               nxt_state = ARB_GNT_I;
            end
         end
         ARB_GNT_I: begin
            if (!i_cyc_i) nxt_state = d_cyc_i ? ARB_GNT_D : ARB_IDLE;
         end
         ARB_GNT_D: begin
            if (!d_cyc_i) nxt_state = i_cyc_i ? ARB_GNT_I : ARB_IDLE;
         end
         default: nxt_state = ARB_IDLE;
      endcase
   end

   // Arbiter state, registered grant and last-served master
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state <= ARB_IDLE;
         gnt_o <= 2'b00;
         last  <= SRC_I;
      end else begin
         state <= nxt_state;
         gnt_o <= grant_of(nxt_state);
         if (nxt_state == ARB_GNT_I) begin
            last <= SRC_I;
         end else if (nxt_state == ARB_GNT_D) begin
            last <= SRC_D;
         end
      end
   end

`ifdef WB_ARB_TIMEOUT_EN
   logic granted;
   assign granted = (state != ARB_IDLE);

   wb_bus_arbiter2_wdt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_wdt (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .clr    (s_ack_i | fire | (nxt_state != state)),
      .inc    (granted & s_stb_o & ~s_ack_i),
      .active (granted),
      .fire   (fire)
   );
`else
   logic [7:0] unused_timeout_cyc;
   assign unused_timeout_cyc = TIMEOUT_CYC[7:0];
   assign fire               = 1'b0;
`endif

   assign timeout_o = fire;

   // Slave-side mux; the strobe is withheld in a forced-termination cycle
   always_comb begin
      s_adr_o = 32'd0;
      s_dat_o = 32'd0;
      s_we_o  = 1'b0;
      s_sel_o = 4'h0;
      s_stb_o = 1'b0;
      s_cyc_o = 1'b0;
      case (state)
         ARB_GNT_I: begin
            s_adr_o = i_adr_i;
            s_sel_o = 4'hF;
            s_stb_o = i_cyc_i & ~fire;
            s_cyc_o = i_cyc_i & ~fire;
         end
         ARB_GNT_D: begin
            s_adr_o = d_adr_i;
            s_dat_o = d_dat_i;
            s_we_o  = d_we_i;
            s_sel_o = d_sel_i;
            s_stb_o = d_stb_i & ~fire;
            s_cyc_o = d_cyc_i & ~fire;
         end
         default: ;
      endcase
   end

   assign i_ack_o = (state == ARB_GNT_I) & (s_ack_i | fire);
   assign d_ack_o = (state == ARB_GNT_D) & (s_ack_i | fire);
   assign i_dat_o = (fire && (state == ARB_GNT_I)) ? TIMEOUT_DATA : s_dat_i;
   assign d_dat_o = (fire && (state == ARB_GNT_D)) ? TIMEOUT_DATA : s_dat_i;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_bus_arbiter2
// Desc     : Randomized scoreboard bench for wb_bus_arbiter2: two masters,
//            a random-latency slave, ownership model and expected-data
//            queues. A fixed-priority instance shares the same stimulus.
//            Timeout phase only when WB_ARB_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_bus_arbiter2;

   localparam int          TCYC      = 4;
   localparam logic [31:0] TDATA     = 32'hDEADBEEF;
   localparam int          NCYC      = 500;
   localparam int          RST2      = 200;
   localparam int          TMO_START = 320;
   localparam int          TMO_END   = 400;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] i_adr;
   logic        i_cyc;
   logic [31:0] d_adr, d_dat;
   logic        d_we, d_stb, d_cyc;
   logic [3:0]  d_sel;
   logic [31:0] s_dat;
   logic        s_ack;

   logic [31:0] i_dat_o, d_dat_o, s_adr_o, s_dat_o;
   logic        i_ack_o, d_ack_o, s_we_o, s_stb_o, s_cyc_o, timeout_o;
   logic [3:0]  s_sel_o;
   logic [1:0]  gnt_o;

   logic [31:0] unused_fp_i_dat, unused_fp_d_dat, unused_fp_s_adr, unused_fp_s_dat;
   logic        unused_fp_i_ack, unused_fp_d_ack, unused_fp_s_we, unused_fp_s_stb;
   logic        unused_fp_s_cyc, unused_fp_tmo;
   logic [3:0]  unused_fp_s_sel;
   logic [1:0]  fp_gnt;

   wb_bus_arbiter2 #(.RR_EN(1'b1), .TIMEOUT_CYC(TCYC), .TIMEOUT_DATA(TDATA)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .i_adr_i(i_adr), .i_cyc_i(i_cyc), .i_dat_o(i_dat_o), .i_ack_o(i_ack_o),
      .d_adr_i(d_adr), .d_dat_i(d_dat), .d_we_i(d_we), .d_sel_i(d_sel),
      .d_stb_i(d_stb), .d_cyc_i(d_cyc), .d_dat_o(d_dat_o), .d_ack_o(d_ack_o),
      .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
      .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
      .gnt_o(gnt_o), .timeout_o(timeout_o)
   );

   wb_bus_arbiter2 #(.RR_EN(1'b0), .TIMEOUT_CYC(TCYC), .TIMEOUT_DATA(TDATA)) dut_fp (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .i_adr_i(i_adr), .i_cyc_i(i_cyc), .i_dat_o(unused_fp_i_dat), .i_ack_o(unused_fp_i_ack),
      .d_adr_i(d_adr), .d_dat_i(d_dat), .d_we_i(d_we), .d_sel_i(d_sel),
      .d_stb_i(d_stb), .d_cyc_i(d_cyc), .d_dat_o(unused_fp_d_dat), .d_ack_o(unused_fp_d_ack),
      .s_adr_o(unused_fp_s_adr), .s_dat_o(unused_fp_s_dat), .s_we_o(unused_fp_s_we),
      .s_sel_o(unused_fp_s_sel), .s_stb_o(unused_fp_s_stb), .s_cyc_o(unused_fp_s_cyc),
      .s_dat_i(s_dat), .s_ack_i(s_ack), .gnt_o(fp_gnt), .timeout_o(unused_fp_tmo)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] iq[$];
   logic [31:0] dq[$];
   bit          i_acked = 1'b0;
   bit          d_acked = 1'b0;
   bit          done    = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Slave read data as a fixed function of the address it was given
   function automatic logic [31:0] rd_f(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0000_0013;
   endfunction

   // Ownership rule: 0 none, 1 IBUS, 2 DBUS
   function automatic int nxt_owner(input int cur, input int lst, input bit rr,
                                    input logic ic, input logic dc);
      if (cur == 1 && ic) return 1;
      if (cur == 2 && dc) return 2;
      if (ic && dc) return (rr && lst == 2) ? 1 : 2;
      if (dc) return 2;
      if (ic) return 1;
      return 0;
   endfunction

   function automatic logic [1:0] onehot(input int o);
      return (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00;
   endfunction

   // Monitor / scoreboard: samples just before each rising edge
   initial begin : monitor
      int own, own_fp, last_m, last_fp, stall, nx, nx_fp;
      logic tmo, e_cyc, e_stb, raw_stb, e_we;
      logic [31:0] e_adr, e_dat, ex;
      logic [3:0]  e_sel;
      own = 0; own_fp = 0; last_m = 1; last_fp = 1; stall = 0;
      @(posedge clk);
      while (!done) begin
         @(negedge clk);
         #4;
         tmo = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
         tmo = (own != 0) && (stall == TCYC);
`endif
         e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_adr = 32'd0; e_dat = 32'd0; e_sel = 4'h0;
         if (own == 1) begin
            e_cyc = i_cyc; e_stb = i_cyc; e_adr = i_adr; e_sel = 4'hF;
         end else if (own == 2) begin
            e_cyc = d_cyc; e_stb = d_stb; e_adr = d_adr; e_dat = d_dat;
            e_we = d_we; e_sel = d_sel;
         end
         raw_stb = e_stb;
         if (tmo) begin
            e_cyc = 1'b0; e_stb = 1'b0;
         end
         chk("gnt",     32'(gnt_o),     32'(onehot(own)));
         chk("gnt_fp",  32'(fp_gnt),    32'(onehot(own_fp)));
         chk("s_cyc",   32'(s_cyc_o),   32'(e_cyc));
         chk("s_stb",   32'(s_stb_o),   32'(e_stb));
         chk("s_adr",   s_adr_o,        e_adr);
         chk("s_dat",   s_dat_o,        e_dat);
         chk("s_we",    32'(s_we_o),    32'(e_we));
         chk("s_sel",   32'(s_sel_o),   32'(e_sel));
         chk("i_ack",   32'(i_ack_o),   32'((own == 1) && (s_ack || tmo)));
         chk("d_ack",   32'(d_ack_o),   32'((own == 2) && (s_ack || tmo)));
         chk("timeout", 32'(timeout_o), 32'(tmo));
         if (i_ack_o) begin
            i_acked = 1'b1;
            if (iq.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL i_ack_unexpected: got ack, want no pending ibus transfer at t=%0t", $time);
            end else begin
               ex = iq.pop_front();
               chk("i_dat", i_dat_o, tmo ? TDATA : ex);
            end
         end
         if (d_ack_o) begin
            d_acked = 1'b1;
            if (dq.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL d_ack_unexpected: got ack, want no pending dbus transfer at t=%0t", $time);
            end else begin
               ex = dq.pop_front();
               chk("d_dat", d_dat_o, tmo ? TDATA : ex);
            end
         end
         if (rst) begin
            nx = 0; nx_fp = 0; last_m = 1; last_fp = 1; stall = 0;
         end else begin
            nx    = nxt_owner(own, last_m, 1'b1, i_cyc, d_cyc);
            nx_fp = nxt_owner(own_fp, last_fp, 1'b0, i_cyc, d_cyc);
            if (tmo || s_ack || nx != own) stall = 0;
            else if (own != 0 && raw_stb) stall++;
            if (nx != 0) last_m = nx;
            if (nx_fp != 0) last_fp = nx_fp;
         end
         own    = nx;
         own_fp = nx_fp;
      end
   end

   // Stimulus: two random masters and a random-latency slave, driven mid-cycle
   initial begin : driver
      bit i_busy, d_busy, issue_en, abort_en, mute;
      int i_gap, d_gap, sw, sdly;
      i_gap = 0; d_gap = 0; sw = 0; sdly = 2;
      rst = 1'b1; s_ack = 1'b0; s_dat = 32'd0;
      i_busy = 1'b1; i_cyc = 1'b1; i_adr = 32'h0000_0100;
      iq.push_back(rd_f(i_adr));
      d_busy = 1'b1; d_cyc = 1'b1; d_stb = 1'b1; d_adr = 32'h2000_0004;
      d_dat = 32'h0000_00AB; d_sel = 4'b0001; d_we = 1'b1;
      dq.push_back(rd_f(d_adr));
      for (int n = 0; n < NCYC; n++) begin
         @(negedge clk);
         rst      = (n == 0) || (n == RST2);
         issue_en = (n < NCYC - 30);
         abort_en = (n > 20) && (n < 300);
         mute     = (n == 0);
`ifdef WB_ARB_TIMEOUT_EN
         if (n >= TMO_START && n < TMO_END) mute = 1'b1;
`endif
         if (i_busy) begin
            if (i_acked) begin
               i_busy = 1'b0; i_cyc = 1'b0; i_gap = $urandom_range(0, 2);
            end else if (abort_en && $urandom_range(0, 15) == 0) begin
               i_busy = 1'b0; i_cyc = 1'b0;
               if (iq.size() != 0) void'(iq.pop_back());
            end
         end else if (i_gap > 0) begin
            i_gap--;
         end else if (issue_en && $urandom_range(0, 3) != 0) begin
            i_busy = 1'b1; i_cyc = 1'b1;
            i_adr  = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            iq.push_back(rd_f(i_adr));
         end
         if (d_busy) begin
            if (d_acked) begin
               d_busy = 1'b0; d_cyc = 1'b0; d_stb = 1'b0; d_gap = $urandom_range(0, 2);
            end else if (abort_en && $urandom_range(0, 15) == 0) begin
               d_busy = 1'b0; d_cyc = 1'b0; d_stb = 1'b0;
               if (dq.size() != 0) void'(dq.pop_back());
            end
         end else if (d_gap > 0) begin
            d_gap--;
         end else if (issue_en && $urandom_range(0, 3) != 0) begin
            d_busy = 1'b1; d_cyc = 1'b1; d_stb = 1'b1;
            d_adr  = $urandom() & 32'hFFFF_FFFC;
            d_dat  = $urandom();
            d_we   = 1'($urandom_range(0, 1));
            d_sel  = 4'($urandom_range(1, 15));
            dq.push_back(rd_f(d_adr));
         end
         i_acked = 1'b0;
         d_acked = 1'b0;
         #1;
         if (rst || mute) begin
            s_ack = 1'b0; sw = 0; s_dat = $urandom();
         end else if (s_cyc_o && s_stb_o) begin
            if (sw >= sdly) begin
               s_ack = 1'b1; s_dat = rd_f(s_adr_o); sw = 0; sdly = $urandom_range(0, 2);
            end else begin
               s_ack = 1'b0; sw++; s_dat = $urandom();
            end
         end else begin
            s_ack = 1'b0; sw = 0; s_dat = $urandom();
         end
      end
      done = 1'b1;
      repeat (3) @(negedge clk);
      chk("ibus_pending_at_end", 32'(iq.size()), 32'd0);
      chk("dbus_pending_at_end", 32'(dq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no end of run, want finish within 200000 time units");
      $fatal(1);
   end

endmodule
`default_nettype wire
